// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared constants for the pipelined multi-lane comparator
package comp_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_LANES     = 4;
    localparam int DEF_CNTWIDTH  = 16;

    // One-hot lane result encoding produced by comp_lane
    localparam logic [2:0] FLAG_LT = 3'b001;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_GT = 3'b100;

endpackage

// File: rtl/comp_lane.sv
// rtl/comp_lane.sv - combinational signed/unsigned compare of one operand lane
module comp_lane
    import comp_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 signed_mode,
    output logic [2:0]           flags
);

    // Equality is mode independent; ordering uses the lane's own width only
    always_comb begin
        flags = FLAG_EQ;
        if (a != b) begin
            if (signed_mode) begin
                flags = ($signed(a) > $signed(b)) ? FLAG_GT : FLAG_LT;
            end else begin
                flags = (a > b) ? FLAG_GT : FLAG_LT;
            end
        end
    end

endmodule

// File: rtl/comp_pipe.sv
// rtl/comp_pipe.sv - two-stage multi-lane comparator with handshake and all-equal counter
module comp_pipe
    import comp_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       signed_mode,
    input  logic [LANES*DATAWIDTH-1:0] a,
    input  logic [LANES*DATAWIDTH-1:0] b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           gt,
    output logic [LANES-1:0]           lt,
    output logic [LANES-1:0]           eq,
    output logic                       all_eq,
    output logic                       any_gt,
    input  logic                       clr_cnt,
    output logic [CNTWIDTH-1:0]        eq_cnt
);

    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    logic [LANES-1:0] c_gt;
    logic [LANES-1:0] c_lt;
    logic [LANES-1:0] c_eq;

    logic             s1_valid;
    logic [LANES-1:0] s1_gt;
    logic [LANES-1:0] s1_lt;
    logic [LANES-1:0] s1_eq;
    logic             s2_valid;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic             drop;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [2:0] flags;
            comp_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
                .a           (a[gi*DATAWIDTH +: DATAWIDTH]),
                .b           (b[gi*DATAWIDTH +: DATAWIDTH]),
                .signed_mode (signed_mode),
                .flags       (flags)
            );
            assign c_gt[gi] = |(flags & FLAG_GT);
            assign c_lt[gi] = |(flags & FLAG_LT);
            assign c_eq[gi] = |(flags & FLAG_EQ);
        end
    endgenerate

    // A stage may load when it is empty or its content moves on this cycle;
    // out_ready ripples straight through to in_ready, so a full pipe keeps streaming
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load && !Rst;
        accept   = in_valid && in_ready;
        drop     = s2_valid && out_ready;
    end

    assign out_valid = s2_valid;

    // S1: capture lane flags with the beat, so later signed_mode changes cannot touch it
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_gt    <= '0;
            s1_lt    <= '0;
            s1_eq    <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_gt <= c_gt;
                s1_lt <= c_lt;
                s1_eq <= c_eq;
            end
        end
    end

    // S2: register lane flags and the lane reductions; holds while stalled
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s2_valid <= 1'b0;
            gt       <= '0;
            lt       <= '0;
            eq       <= '0;
            all_eq   <= 1'b0;
            any_gt   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                gt     <= s1_gt;
                lt     <= s1_lt;
                eq     <= s1_eq;
                all_eq <= &s1_eq;
                any_gt <= |s1_gt;
            end
        end
    end

    // Saturating count of delivered all-equal beats; clear beats a same-cycle increment
    always_ff @(posedge Clk) begin
        if (Rst || clr_cnt) begin
            eq_cnt <= '0;
        end else if (drop && all_eq && (eq_cnt != CNT_MAX)) begin
            eq_cnt <= eq_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_comp_pipe.sv
// tb/tb_comp_pipe.sv - self-checking bench for comp_pipe
module tb_comp_pipe;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          signed_mode = 1'b0;
    logic [LN*DW-1:0] a = '0;
    logic [LN*DW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LN-1:0] gt, lt, eq;
    logic          all_eq, any_gt;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] eq_cnt;

    logic          in_ready2, out_valid2, all_eq2, any_gt2;
    logic [LN-1:0] gt2, lt2, eq2;
    logic [1:0]    eq_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    comp_pipe #(.DATAWIDTH(DW), .LANES(LN), .CNTWIDTH(CW)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .gt(gt), .lt(lt), .eq(eq), .all_eq(all_eq),
        .any_gt(any_gt), .clr_cnt(clr_cnt), .eq_cnt(eq_cnt)
    );

    comp_pipe #(.DATAWIDTH(DW), .LANES(LN), .CNTWIDTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready2),
        .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid2),
        .out_ready(out_ready), .gt(gt2), .lt(lt2), .eq(eq2), .all_eq(all_eq2),
        .any_gt(any_gt2), .clr_cnt(clr_cnt), .eq_cnt(eq_cnt2)
    );

    typedef struct {
        logic          sm;
        logic [31:0]   va;
        logic [31:0]   vb;
        logic [3:0]    e_gt;
        logic [3:0]    e_lt;
        logic [3:0]    e_eq;
        logic          e_all;
        logic          e_any;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] pats[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_out(input string name);
        int k;
        for (k = 0; k < 8 && out_valid !== 1'b1; k++) step();
        check(name, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic do_reset();
        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        step();
        Rst = 1'b0;
        #1;
    endtask

    task automatic send_eq_beats(input int n);
        for (int i = 0; i < n; i++) begin
            a = 32'h5A5A5A5A; b = 32'h5A5A5A5A; in_valid = 1'b1; out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        int sent, recv;
        logic [3:0] pat;

        vecs[0] = '{1'b0, 32'hFF058010, 32'h00067F10, 4'b1010, 4'b0100, 4'b0001, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'hFF058010, 32'h00067F10, 4'b0000, 4'b1110, 4'b0001, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h7F010080, 32'h80FF007F, 4'b1100, 4'b0001, 4'b0010, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h7F010080, 32'h80FF007F, 4'b0001, 4'b1100, 4'b0010, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h01FF807F, 32'h01FF807F, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0};
        pats[0] = 4'b0001; pats[1] = 4'b0110; pats[2] = 4'b1000;
        pats[3] = 4'b1011; pats[4] = 4'b0101;

        // Reset state
        Rst = 1'b1;
        step(); step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_flags", {52'd0, gt, lt, eq}, 64'd0);
        check("rst_red", {62'd0, all_eq, any_gt}, 64'd0);
        check("rst_cnt", {48'd0, eq_cnt}, 64'd0);
        Rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Table vectors; signed_mode is flipped right after acceptance
        foreach (vecs[i]) begin
            a = vecs[i].va; b = vecs[i].vb; signed_mode = vecs[i].sm;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0; signed_mode = ~vecs[i].sm; a = '0; b = 32'hFFFFFFFF;
            step();
            check($sformatf("v%0d_latency", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("v%0d_gt", i), {60'd0, gt}, {60'd0, vecs[i].e_gt});
            check($sformatf("v%0d_lt", i), {60'd0, lt}, {60'd0, vecs[i].e_lt});
            check($sformatf("v%0d_eq", i), {60'd0, eq}, {60'd0, vecs[i].e_eq});
            check($sformatf("v%0d_red", i), {62'd0, all_eq, any_gt}, {62'd0, vecs[i].e_all, vecs[i].e_any});
            step();
        end
        check("table_cnt", {48'd0, eq_cnt}, 64'd2);

        // Backpressure: 5 beats, out_ready low for the first 4 cycles
        do_reset();
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            in_valid = (sent < 5);
            pat = (sent < 5) ? pats[sent] : 4'b0000;
            for (int l = 0; l < LN; l++) begin
                a[l*DW +: DW] = {7'd0, pat[l]};
                b[l*DW +: DW] = 8'd0;
            end
            signed_mode = 1'b0;
            out_ready = (cyc >= 4);
            #1;
            if (cyc == 2) begin
                check("bp_accepts", sent, 2);
                check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (cyc == 3) begin
                check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
                check("bp_stall_gt", {60'd0, gt}, {60'd0, pats[0]});
                check("bp_stall_eq", {60'd0, eq}, {60'd0, ~pats[0]});
            end
            if (cyc == 4) check("bp_passthru_in_ready", {63'd0, in_ready}, 64'd1);
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", recv), {60'd0, gt}, {60'd0, pats[recv]});
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        check("bp_recv", recv, 5);
        step(); step();
        check("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Counter and saturation in the 2-bit build
        do_reset();
        send_eq_beats(3);
        check("cnt3", {48'd0, eq_cnt}, 64'd3);
        check("cnt3_w2", {62'd0, eq_cnt2}, 64'd3);
        send_eq_beats(2);
        check("cnt5", {48'd0, eq_cnt}, 64'd5);
        check("cnt_sat_w2", {62'd0, eq_cnt2}, 64'd3);

        // Clear coincident with an all-equal drop
        a = 32'h5A5A5A5A; b = 32'h5A5A5A5A; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out("clr_wait");
        check("clr_pre_all_eq", {63'd0, all_eq}, 64'd1);
        out_ready = 1'b1; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        #1;
        check("clr_wins", {48'd0, eq_cnt}, 64'd0);

        // Reset with two beats in flight
        send_eq_beats(1);
        check("pre_rst_cnt", {48'd0, eq_cnt}, 64'd1);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h5A5A5A5A; b = 32'h5A5A5A5A;
        step(); step();
        in_valid = 1'b0;
        check("inflight_valid", {63'd0, out_valid}, 64'd1);
        Rst = 1'b1;
        #1;
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        Rst = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_mid_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_cnt", {48'd0, eq_cnt}, 64'd0);
        step(); step();
        check("rst_mid_discard", {63'd0, out_valid}, 64'd0);
        check("rst_mid_cnt_hold", {48'd0, eq_cnt}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
